// File: rtl/alk_rot_pkg.sv
// ---------------------------------------------------------------------------
// alk_rot_pkg
//   Shared definitions for the sequenced ALK ROT-field executor:
//   default field widths, the default "modifies S/P" and "multi-cycle"
//   ROT maps, and the two-state sequencer enum.
// ---------------------------------------------------------------------------
package alk_rot_pkg;

  localparam int ALK_ROT_W = 6;
  localparam int ALK_CNT_W = 5;

  // ROT values that write the S or P latch on their final iteration.
  localparam logic [63:0] ALK_MODSP_MAP = (64'd1 << 8'h27) |
                                          (64'd1 << 8'h2D) |
                                          (64'd1 << 8'h2F) |
                                          (64'd1 << 8'h3B) |
                                          (64'd1 << 8'h3D) |
                                          (64'd1 << 8'h3F);

  // ROT values 0x38..0x3F iterate cnt_h times instead of once.
  localparam logic [63:0] ALK_MULTI_MAP = 64'hFF00_0000_0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } alk_state_e;

endpackage : alk_rot_pkg

// File: rtl/alk_rot_lut.sv
// ---------------------------------------------------------------------------
// alk_rot_lut
//   One-bit lookup of a ROT value into a 2^IDX_W-entry bit map.
//   Ports:
//     idx_h  in  IDX_W  ROT value used as table index
//     hit_h  out 1      MAP bit selected by idx_h
// ---------------------------------------------------------------------------
module alk_rot_lut #(
  parameter int                    IDX_W = 6,
  parameter logic [2**IDX_W-1:0]   MAP   = '0
) (
  input  logic [IDX_W-1:0] idx_h,
  output logic             hit_h
);

  assign hit_h = MAP[idx_h];

endmodule : alk_rot_lut

// File: rtl/alk_rot_seq.sv
// ---------------------------------------------------------------------------
// alk_rot_seq
//   Sequenced ALK ROT-field executor. Accepts one microword ROT field per
//   handshake and runs it for 1..2^CNT_W-1 rotator iterations, strobing the
//   S/P-latch write (modsp_l, active low) only on the final iteration.
//
//   Handshake: a microword is accepted on a rising clk_h edge where
//   uvld_h & rdy_h. rdy_h is high when idle or on the last iteration of the
//   current op (back-to-back issue without a bubble) and is forced low by
//   flush_h; uvld_h may be held without rdy_h and carries no obligation.
//
//   Ports:
//     clk_h    in   1      system clock, rising edge
//     reset_l  in   1      asynchronous active-low reset
//     uvld_h   in   1      microword valid
//     rot_h    in   ROT_W  ROT micro-op field
//     cnt_h    in   CNT_W  iteration count (multi-cycle ops only, 0 => 1)
//     flush_h  in   1      synchronous abort of the current op
//     rdy_h    out  1      microword can be accepted this cycle
//     busy_h   out  1      an op is executing (state == EXEC)
//     rot_q_h  out  ROT_W  ROT of the executing / last op
//     step_h   out  1      a rotator iteration occurs this cycle
//     done_h   out  1      final iteration pulse
//     modsp_l  out  1      low while the S/P latch is written
// ---------------------------------------------------------------------------
module alk_rot_seq
  import alk_rot_pkg::*;
#(
  parameter int                  ROT_W     = ALK_ROT_W,
  parameter int                  CNT_W     = ALK_CNT_W,
  parameter logic [2**ROT_W-1:0] MODSP_MAP = ALK_MODSP_MAP,
  parameter logic [2**ROT_W-1:0] MULTI_MAP = ALK_MULTI_MAP
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             uvld_h,
  input  logic [ROT_W-1:0] rot_h,
  input  logic [CNT_W-1:0] cnt_h,
  input  logic             flush_h,
  output logic             rdy_h,
  output logic             busy_h,
  output logic [ROT_W-1:0] rot_q_h,
  output logic             step_h,
  output logic             done_h,
  output logic             modsp_l
);

  alk_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [ROT_W-1:0] rot_op_q, rot_op_d;

  logic             multi_hit;
  logic             modsp_hit;
  logic             in_exec;
  logic             last;
  logic             accept;
  logic [CNT_W-1:0] load_rem;

  // Multi-cycle classification is needed for the incoming field, the S/P
  // classification for the op being executed.
  alk_rot_lut #(
    .IDX_W (ROT_W),
    .MAP   (MULTI_MAP)
  ) u_multi_lut (
    .idx_h (rot_h),
    .hit_h (multi_hit)
  );

  alk_rot_lut #(
    .IDX_W (ROT_W),
    .MAP   (MODSP_MAP)
  ) u_modsp_lut (
    .idx_h (rot_op_q),
    .hit_h (modsp_hit)
  );

  assign in_exec = (state_q == EXEC);
  assign last    = in_exec && (rem_q == '0);
  assign rdy_h   = ~flush_h & (~in_exec | last);
  assign accept  = uvld_h & rdy_h;

  // rem counts iterations still to go after the current one, so it loads
  // N-1. A zero count is treated as a single iteration.
  always_comb begin
    load_rem = '0;
    if (multi_hit && (cnt_h != '0)) begin
      load_rem = cnt_h - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    rot_op_d = rot_op_q;
    if (flush_h) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (accept) begin
      rot_op_d = rot_h;
      rem_d    = load_rem;
      state_d  = EXEC;
    end else if (in_exec) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      rot_op_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      rot_op_q <= rot_op_d;
    end
  end

  // busy_h is the FSM state itself (two states), so it doubles as the
  // state observation point.
  assign busy_h  = in_exec;
  assign rot_q_h = rot_op_q;
  assign step_h  = in_exec & ~flush_h;
  assign done_h  = last & ~flush_h;
  assign modsp_l = ~(last & modsp_hit & ~flush_h);

endmodule : alk_rot_seq

// File: tb/tb_alk_rot_seq.sv
// ---------------------------------------------------------------------------
// tb_alk_rot_seq
//   Directed, table-driven bench for alk_rot_seq. Each table row is one clock
//   cycle: inputs are driven on the falling edge and outputs are compared
//   1ns later, well clear of the rising edge. A long multi-cycle run is
//   checked against an expected queue.
// ---------------------------------------------------------------------------
module tb_alk_rot_seq;

  logic       clk_h;
  logic       reset_l;
  logic       uvld_h;
  logic [5:0] rot_h;
  logic [4:0] cnt_h;
  logic       flush_h;
  logic       rdy_h;
  logic       busy_h;
  logic [5:0] rot_q_h;
  logic       step_h;
  logic       done_h;
  logic       modsp_l;

  int n_vec;
  int n_err;

  alk_rot_seq u_dut (
    .clk_h   (clk_h),
    .reset_l (reset_l),
    .uvld_h  (uvld_h),
    .rot_h   (rot_h),
    .cnt_h   (cnt_h),
    .flush_h (flush_h),
    .rdy_h   (rdy_h),
    .busy_h  (busy_h),
    .rot_q_h (rot_q_h),
    .step_h  (step_h),
    .done_h  (done_h),
    .modsp_l (modsp_l)
  );

  // ---------------- clock / reset ----------------
  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  // ---------------- vector table ----------------
  typedef struct {
    logic       rl;
    logic       v;
    logic       fl;
    logic [5:0] rot;
    logic [4:0] cnt;
    logic       rdy;
    logic       busy;
    logic [5:0] rq;
    logic       step;
    logic       done;
    logic       msp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rl, input logic v, input logic fl,
                              input logic [5:0] rot, input logic [4:0] cnt,
                              input logic rdy, input logic busy,
                              input logic [5:0] rq, input logic step,
                              input logic done, input logic msp);
    vec_t r;
    r.rl = rl; r.v = v; r.fl = fl; r.rot = rot; r.cnt = cnt;
    r.rdy = rdy; r.busy = busy; r.rq = rq; r.step = step;
    r.done = done; r.msp = msp;
    return r;
  endfunction

  // Observed outputs packed {rdy, busy, rot_q[5:0], step, done, modsp_l}.
  function automatic logic [10:0] pack_out(input logic rdy, input logic busy,
                                           input logic [5:0] rq,
                                           input logic step, input logic done,
                                           input logic msp);
    return {rdy, busy, rq, step, done, msp};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rl, input logic v, input logic fl,
                       input logic [5:0] rot, input logic [4:0] cnt);
    @(negedge clk_h);
    reset_l = rl;
    uvld_h  = v;
    flush_h = fl;
    rot_h   = rot;
    cnt_h   = cnt;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = pack_out(rdy_h, busy_h, rot_q_h, step_h, done_h, modsp_l);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {rdy,busy,rot_q,step,done,modsp_l}=%b_%b_%h_%b_%b_%b expected %b_%b_%h_%b_%b_%b",
               name, act[10], act[9], act[8:3], act[2], act[1], act[0],
               exp[10], exp[9], exp[8:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_l = 1'b0;
    uvld_h  = 1'b0;
    flush_h = 1'b0;
    rot_h   = '0;
    cnt_h   = '0;

    //            rl v  fl rot    cnt     rdy bsy rq     stp dn msp
    // reset state
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h00, 0,0,1));
    // single-cycle S/P op 0x27, cnt ignored
    vecs.push_back(mk(1,1,0,6'h27,5'd9,   1,0,6'h00, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,1,6'h27, 1,1,0));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h27, 0,0,1));
    // non-modifying 0x10, cnt ignored
    vecs.push_back(mk(1,1,0,6'h10,5'd5,   1,0,6'h27, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,1,6'h10, 1,1,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h10, 0,0,1));
    // 0x3D x4, then 0x2D held valid -> back-to-back
    vecs.push_back(mk(1,1,0,6'h3D,5'd4,   1,0,6'h10, 0,0,1));
    vecs.push_back(mk(1,1,0,6'h2D,5'd0,   0,1,6'h3D, 1,0,1));
    vecs.push_back(mk(1,1,0,6'h2D,5'd0,   0,1,6'h3D, 1,0,1));
    vecs.push_back(mk(1,1,0,6'h2D,5'd0,   0,1,6'h3D, 1,0,1));
    vecs.push_back(mk(1,1,0,6'h2D,5'd0,   1,1,6'h3D, 1,1,0));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,1,6'h2D, 1,1,0));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h2D, 0,0,1));
    // multi op with cnt=0 runs once
    vecs.push_back(mk(1,1,0,6'h3B,5'd0,   1,0,6'h2D, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,1,6'h3B, 1,1,0));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h3B, 0,0,1));
    // 0x3F x3 flushed in its 2nd cycle; uvld in the flush cycle dropped
    vecs.push_back(mk(1,1,0,6'h3F,5'd3,   1,0,6'h3B, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   0,1,6'h3F, 1,0,1));
    vecs.push_back(mk(1,1,1,6'h27,5'd0,   0,1,6'h3F, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h3F, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h3F, 0,0,1));
    // flush while idle only blocks the offered word
    vecs.push_back(mk(1,1,1,6'h10,5'd0,   0,0,6'h3F, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h3F, 0,0,1));
    // flush on the last (S/P writing) cycle suppresses the write
    vecs.push_back(mk(1,1,0,6'h27,5'd0,   1,0,6'h3F, 0,0,1));
    vecs.push_back(mk(1,0,1,6'h00,5'd0,   0,1,6'h27, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h27, 0,0,1));
    // 0x3F x3 aborted by reset in its 2nd cycle
    vecs.push_back(mk(1,1,0,6'h3F,5'd3,   1,0,6'h27, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   0,1,6'h3F, 1,0,1));
    vecs.push_back(mk(0,0,0,6'h00,5'd0,   1,0,6'h00, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h00, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h00, 0,0,1));
    // multi, non-modifying 0x38 x2
    vecs.push_back(mk(1,1,0,6'h38,5'd2,   1,0,6'h00, 0,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   0,1,6'h38, 1,0,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,1,6'h38, 1,1,1));
    vecs.push_back(mk(1,0,0,6'h00,5'd0,   1,0,6'h38, 0,0,1));

    repeat (3) @(negedge clk_h);

    foreach (vecs[i]) begin
      drive(vecs[i].rl, vecs[i].v, vecs[i].fl, vecs[i].rot, vecs[i].cnt);
      check($sformatf("vec%0d", i),
            pack_out(vecs[i].rdy, vecs[i].busy, vecs[i].rq,
                     vecs[i].step, vecs[i].done, vecs[i].msp));
    end

    // Maximum count: 0x3F x31, S/P write only on the 31st step.
    begin
      int steps;
      int msp_at;
      int done_at;
      steps   = 0;
      msp_at  = -1;
      done_at = -1;
      drive(1, 1, 0, 6'h3F, 5'd31);
      check("max_accept", pack_out(1, 0, 6'h38, 0, 0, 1));
      for (int k = 1; k <= 30; k++) exp_q.push_back(pack_out(0, 1, 6'h3F, 1, 0, 1));
      exp_q.push_back(pack_out(1, 1, 6'h3F, 1, 1, 0));
      exp_q.push_back(pack_out(1, 0, 6'h3F, 0, 0, 1));
      for (int k = 1; k <= 32; k++) begin
        logic [10:0] e;
        drive(1, 0, 0, 6'h00, 5'd0);
        if (step_h)    steps++;
        if (!modsp_l)  msp_at  = k;
        if (done_h)    done_at = k;
        e = exp_q.pop_front();
        if (e !== pack_out(rdy_h, busy_h, rot_q_h, step_h, done_h, modsp_l))
          check($sformatf("max_cyc%0d", k), e);
      end
      check_int("max_steps",   steps,   31);
      check_int("max_modsp_at", msp_at, 31);
      check_int("max_done_at", done_at, 31);
      check_int("max_queue_left", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_alk_rot_seq

// File: doc/alk_rot_seq.md
Name: alk_rot_seq

Overview:
- Sequenced successor to the combinational ALK ROT-field decoder (DC615, DPM).
- Accepts one microword ROT field per handshake and executes it for 1..N rotator iterations.
- Drives the S/P-latch modify strobe only on the final iteration.
- ROT width, iteration-count width, the "modifies S/P" set and the "multi-cycle" set are all parameters.

Parameters:
- ROT_W, 6: width of ROT field.
- CNT_W, 5: width of the iteration-count input.
- MODSP_MAP, 2^ROT_W-bit vector with bits {0x27,0x2D,0x2F,0x3B,0x3D,0x3F} set: a ROT value whose bit is set modifies the S or P latch.
- MULTI_MAP, 2^ROT_W-bit vector with bits 0x38..0x3F set: a ROT value whose bit is set is multi-cycle and uses cnt_h.

Ports:
- clk_h  in  1  system clock; all state changes on the rising edge.
- reset_l  in  1  asynchronous active-low reset.
- uvld_h  in  1  microword valid; the ROT field is offered this cycle.
- rot_h  in  ROT_W  ROT micro-op field.
- cnt_h  in  CNT_W  iteration count; used only for MULTI_MAP ops.
- flush_h  in  1  synchronous abort of the current op (trap/microbranch).
- rdy_h  out  1  block can accept a microword this cycle.
- busy_h  out  1  an op is executing.
- rot_q_h  out  ROT_W  registered ROT of the executing op.
- step_h  out  1  one rotator iteration is performed this cycle.
- done_h  out  1  final iteration of the op; one-cycle pulse.
- modsp_l  out  1  low during the cycle the S/P latch is written.

Behaviour:
- Clock and reset: one clock, clk_h. reset_l is asynchronous and active-low.
- Reset values: state IDLE, rot_q_h=0, remaining counter rem=0. Outputs: rdy_h=1, busy_h=0, step_h=0, done_h=0, modsp_l=1.
  - An assertion mid-op discards the op with no S/P write.
- States: IDLE and EXEC.
  - busy_h = (state==EXEC).
  - last = EXEC & (rem==0).
- rdy_h = ~flush_h & (IDLE | last). This is the only output combinational from inputs besides the flush gating below.
- Accept: uvld_h & rdy_h at a rising edge.
  - rot_q_h <= rot_h.
  - Iterations N = MULTI_MAP[rot_h] ? max(cnt_h,1) : 1.
  - rem <= N-1; state <= EXEC.
  - cnt_h=0 is treated as 1. The maximum is 2^CNT_W-1 iterations.
  - cnt_h is ignored for non-MULTI ops.
- EXEC, every cycle:
  - step_h = ~flush_h.
  - done_h = last & ~flush_h.
  - modsp_l = ~(last & MODSP_MAP[rot_q_h] & ~flush_h).
- EXEC, next state:
  - If not last: rem <= rem-1.
  - If last with an accept in the same cycle: reload per Accept (back-to-back, no bubble).
  - If last without an accept: state <= IDLE and rot_q_h is held.
- IDLE: step_h=0, done_h=0, modsp_l=1.
- Latency: an op accepted at edge k has its first step at cycle k+1. done_h and modsp_l fall in cycle k+N.
- flush_h (synchronous, highest priority):
  - Next state IDLE, rem <= 0.
  - Any uvld_h in that cycle is dropped (rdy_h=0).
  - step_h, done_h and modsp_l are suppressed in the flush cycle.
  - Flush while IDLE has no effect beyond rdy_h=0.
- rot_q_h changes only on accept or reset.
- At most one modsp_l low cycle per accepted op; none for flushed ops.

Decomposition:
- Package alk_rot_pkg holds:
  - ROT_W and CNT_W defaults.
  - The default MODSP_MAP and MULTI_MAP constants.
  - The state enum {IDLE, EXEC}.
- Sub-module alk_rot_lut: parametrised 2^ROT_W-bit table lookup (ROT value -> 1 bit).
  - Instantiated twice: once on rot_h for MULTI, once on rot_q_h for MODSP.

Test Plan:
- Reset: hold reset_l=0, then release -> rdy_h=1, busy_h=0, modsp_l=1, step_h=0, done_h=0, rot_q_h=0.
- Single-cycle S/P op: uvld_h=1, rot_h=0x27, cnt_h=9 accepted at edge 1 -> in cycle 2: busy_h=1, step_h=1, done_h=1, modsp_l=0, rot_q_h=0x27. Cycle 3: IDLE, modsp_l=1.
- Non-modifying op: rot_h=0x10 -> one-cycle done_h pulse, modsp_l stays 1 throughout.
- Multi-cycle with back-to-back accept:
  - Stimulus: rot_h=0x3D, cnt_h=4; then uvld_h held with rot_h=0x2D.
  - step_h=1 for 4 cycles; rdy_h=0 in cycles 1-3 and 1 in cycle 4.
  - done_h=1 and modsp_l=0 only in cycle 4.
  - 0x2D accepted at the end of cycle 4; its done/modsp_l fall in the very next cycle.
- Count edge: rot_h=0x3B, cnt_h=0 -> executes 1 cycle with modsp_l=0. rot_h=0x3F, cnt_h=31 -> 31 steps, modsp_l low only on the 31st.
- Abort:
  - 0x3F with cnt_h=3, flush_h=1 in cycle 2 -> step_h=0 that cycle, IDLE next, done_h and modsp_l never asserted.
  - Repeat with reset_l pulsed low in cycle 2 -> same result, and rot_q_h=0.
